// File: rtl/i2c_slave_write_byte.sv
// Byte transmit sequencer for the I2C slave read path: shifts a byte onto SDA
// MSB-first across SCL low phases, then releases SDA and samples the master ACK.
module i2c_slave_write_byte (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       busy,
  output logic       finish,
  output logic       ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_ACK
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       scl_last_q, scl_last_d;
  logic       sda_out_q, sda_out_d;
  logic       busy_q, busy_d;
  logic       finish_q, finish_d;
  logic       ack_q, ack_d;

  logic       scl_rise;
  logic       scl_fall;

  assign scl_rise = ~scl_last_q & scl;
  assign scl_fall = scl_last_q & ~scl;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sda_out_d  = sda_out_q;
    ack_d      = ack_q;
    finish_d   = 1'b0;
    scl_last_d = scl;

    // SDA is only ever updated on a cycle where scl is low (enable & ~scl, or a fall)
    case (state_q)
      S_IDLE: begin
        if (enable && !scl) begin
          shift_d   = data_in;
          bit_cnt_d = 3'd7;
          sda_out_d = data_in[7];
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (scl_rise) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
            sda_out_d = shift_q[6];
            state_d   = S_SEND;
          end else begin
            sda_out_d = 1'b1;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (scl_rise) begin
          ack_d    = ~sda_in;
          finish_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        sda_out_d = 1'b1;
      end
    endcase

    // busy stays up through the finish cycle and drops one clock later
    busy_d = (state_d != S_IDLE) | finish_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      scl_last_q <= 1'b1;
      sda_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      scl_last_q <= scl_last_d;
      sda_out_q  <= sda_out_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      ack_q      <= ack_d;
    end
  end

  assign sda_out = sda_out_q;
  assign busy    = busy_q;
  assign finish  = finish_q;
  assign ack     = ack_q;

endmodule

// File: tb/tb_i2c_slave_write_byte.sv
// Self-checking bench for i2c_slave_write_byte: a small I2C master model drives
// SCL and the ACK bit; a scoreboard of expected SDA bits and ACK values is checked.
module tb_i2c_slave_write_byte;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [7:0] data_in;
  logic       scl;
  logic       sda_in;
  logic       sda_out;
  logic       busy;
  logic       finish;
  logic       ack;

  int n_checks = 0;
  int n_fail   = 0;
  int fin_cnt  = 0;

  bit exp_q[$];
  bit obs_q[$];
  bit exp_ack_q[$];
  bit obs_ack_q[$];

  logic busy_at_fin   = 1'b0;
  logic busy_after    = 1'b1;
  logic fin_prev      = 1'b0;
  logic prev_scl      = 1'b1;
  logic prev_sda      = 1'b1;

  i2c_slave_write_byte dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .data_in (data_in),
    .scl     (scl),
    .sda_in  (sda_in),
    .sda_out (sda_out),
    .busy    (busy),
    .finish  (finish),
    .ack     (ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, fin_cnt=%0d", fin_cnt);
    $fatal(1, "timeout");
  end

  // Finish / ACK monitor, sampled on the falling clock edge
  always @(negedge clock) begin
    if (fin_prev) busy_after = busy;
    fin_prev = finish;
    if (finish === 1'b1) begin
      fin_cnt++;
      obs_ack_q.push_back(ack);
      busy_at_fin = busy;
    end
  end

  // SDA must never move while SCL stays high
  always @(negedge clock) begin
    if (reset_n === 1'b1 && prev_scl === 1'b1 && scl === 1'b1) begin
      n_checks++;
      if (sda_out !== prev_sda) begin
        n_fail++;
        $display("FAIL sda_stable_while_scl_high: sda_out=%b, required %b at %0t", sda_out, prev_sda, $time);
      end
    end
    prev_scl = scl;
    prev_sda = sda_out;
  end

  task automatic push_byte(input logic [7:0] b, input bit ack_exp);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
    exp_ack_q.push_back(ack_exp);
  endtask

  task automatic start_byte(input logic [7:0] b);
    @(posedge clock); #1;
    enable  = 1'b1;
    data_in = b;
    @(posedge clock); #1;
    enable  = 1'b0;
    data_in = 8'($urandom);
  endtask

  // One SCL clock: 3 low clocks, 3 high clocks; sda_out captured mid high phase
  task automatic scl_pulse(input bit sda_drive, input bit inject);
    sda_in = sda_drive;
    @(posedge clock); #1;
    if (inject) begin
      enable  = 1'b1;
      data_in = 8'hFF;
    end
    @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); #1;
    scl = 1'b1;
    @(posedge clock);
    @(negedge clock);
    obs_q.push_back(sda_out);
    @(posedge clock); #1;
    @(posedge clock); #1;
    scl    = 1'b0;
    sda_in = 1'b1;
  endtask

  task automatic run_byte(input logic [7:0] b, input bit ack_drive, input int inject_at);
    start_byte(b);
    for (int i = 0; i < 9; i++) scl_pulse((i == 8) ? ack_drive : 1'b1, i == inject_at);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable  = 1'b0;
    data_in = 8'h00;
    scl     = 1'b1;
    sda_in  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({sda_out, busy, finish, ack} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state: {sda_out,busy,finish,ack}=%b, required 1000", {sda_out, busy, finish, ack});
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_enable_scl_high;
    int f0;
    f0 = fin_cnt;
    scl = 1'b1;
    @(posedge clock); #1;
    enable  = 1'b1;
    data_in = 8'h00;
    @(posedge clock); #1;
    enable = 1'b0;
    repeat (4) begin
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0 || sda_out !== 1'b1) begin
        n_fail++;
        $display("FAIL enable_scl_high_ignored: busy=%b sda_out=%b, required busy=0 sda_out=1", busy, sda_out);
      end
    end
    @(posedge clock); #1;
    scl = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (fin_cnt != f0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_scl_high_no_finish: finishes=%0d busy=%b, required 0 and 0", fin_cnt - f0, busy);
    end
  endtask

  task automatic check_scoreboard(input string name, input int fins_exp, input int f0);
    bit e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_sda_bit: sda_out=%b, required %b (bits left %0d)", name, o, e, exp_q.size());
      end
    end
    obs_q.delete();
    n_checks++;
    if (fin_cnt - f0 != fins_exp) begin
      n_fail++;
      $display("FAIL %s_finish_count: got %0d pulses, required %0d", name, fin_cnt - f0, fins_exp);
    end
    while (exp_ack_q.size() > 0) begin
      e = exp_ack_q.pop_front();
      o = (obs_ack_q.size() > 0) ? obs_ack_q.pop_front() : ~e;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_ack: ack=%b, required %b", name, o, e);
      end
    end
    obs_ack_q.delete();
  endtask

  task automatic test_byte_a5_ack;
    int f0;
    f0 = fin_cnt;
    push_byte(8'hA5, 1'b1);
    @(posedge clock); #1;
    enable  = 1'b1;
    data_in = 8'hA5;
    @(posedge clock); #1;
    enable  = 1'b0;
    data_in = 8'h5A;
    @(negedge clock);
    n_checks++;
    if (sda_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_first_bit: sda_out=%b busy=%b, required 1 and 1", sda_out, busy);
    end
    for (int i = 0; i < 9; i++) scl_pulse((i == 8) ? 1'b0 : 1'b1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_ack_held: ack=%b, required 1", ack);
    end
    check_scoreboard("a5", 1, f0);
  endtask

  task automatic test_byte_3c_nack;
    int f0;
    f0 = fin_cnt;
    push_byte(8'h3C, 1'b0);
    run_byte(8'h3C, 1'b1, -1);
    n_checks++;
    if (busy_at_fin !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL 3c_busy_drop: busy at finish=%b after=%b, required 1 and 0", busy_at_fin, busy_after);
    end
    check_scoreboard("3c", 1, f0);
  endtask

  task automatic test_enable_while_busy;
    int f0;
    f0 = fin_cnt;
    push_byte(8'h00, 1'b1);
    run_byte(8'h00, 1'b0, 4);
    repeat (6) @(posedge clock);
    #1;
    check_scoreboard("busy_ignore", 1, f0);
  endtask

  task automatic test_reset_midbyte;
    int f0;
    f0 = fin_cnt;
    start_byte(8'h81);
    scl_pulse(1'b1, 1'b0);
    scl_pulse(1'b1, 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({sda_out, busy, finish} !== 3'b100) begin
      n_fail++;
      $display("FAIL midbyte_reset_async: {sda_out,busy,finish}=%b, required 100", {sda_out, busy, finish});
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    obs_q.delete();
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (fin_cnt != f0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midbyte_reset_no_finish: finishes=%0d busy=%b, required 0 and 0", fin_cnt - f0, busy);
    end
    f0 = fin_cnt;
    push_byte(8'h81, 1'b1);
    run_byte(8'h81, 1'b0, -1);
    check_scoreboard("after_reset_81", 1, f0);
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = fin_cnt;
    push_byte(8'h12, 1'b1);
    push_byte(8'h34, 1'b0);
    run_byte(8'h12, 1'b0, -1);
    run_byte(8'h34, 1'b1, -1);
    repeat (4) @(posedge clock);
    #1;
    check_scoreboard("back_to_back", 2, f0);
  endtask

  initial begin
    test_reset();
    test_enable_scl_high();
    test_byte_a5_ack();
    test_byte_3c_nack();
    test_enable_while_busy();
    test_reset_midbyte();
    test_back_to_back();
    repeat (4) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
